// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory mode encodings,
// RISC-V load/store funct3 codes, FSM states and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] MODE_WORD = 3'b100;
    localparam logic [2:0] MODE_HALF = 3'b010;
    localparam logic [2:0] MODE_BYTE = 3'b001;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Loads accept B/H/W/BU/HU, stores only B/H/W.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Size lives in funct3[1:0]: 0 byte, 1 half, 2 word.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'd1:    return a[0];
            2'd2:    return a != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] size_mode(input logic [2:0] f3);
        case (f3[1:0])
            2'd1:    return MODE_HALF;
            2'd2:    return MODE_WORD;
            default: return MODE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension: picks byte/half/word from the low lanes and applies
// sign or zero extension according to funct3.
import lsu_pkg::*;

module load_extend (
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    // Select width and extension kind from funct3.
    always_comb begin
        ext = data;
        case (funct3)
            F3_B:    ext = {{24{data[7]}}, data[7:0]};
            F3_H:    ext = {{16{data[15]}}, data[15:0]};
            F3_BU:   ext = {24'd0, data[7:0]};
            F3_HU:   ext = {16'd0, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP.
// Misaligned accesses are split into byte accesses, lowest byte first.
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses return an error
// instead of being split.
import lsu_pkg::*;

module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [2:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif

    state_t            state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              split_q;
    logic [1:0]        cnt_q;
    logic [1:0]        last_q;
    logic [31:0]       rbuf_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              req_mis;
    logic              req_bad;
    logic              last_beat;
    logic [31:0]       merged;
    logic [31:0]       ext_data;

    assign req_mis   = misaligned(req_funct3, req_addr[1:0]);
    assign req_bad   = !f3_legal(req_we, req_funct3) || (TRAP_MISALIGN && req_mis);
    assign last_beat = (cnt_q == last_q);

    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Load bytes collected so far with this cycle's read merged in.
    always_comb begin
        merged = mem_rdata;
        if (split_q) begin
            merged = rbuf_q;
            merged[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
        end
    end

    load_extend u_ext (
        .data   (merged),
        .funct3 (f3_q),
        .ext    (ext_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and memory-side outputs; memory outputs idle at zero.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_mode  = 3'b000;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_we = we_q;
                if (split_q) begin
                    mem_mode  = MODE_BYTE;
                    mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
                    mem_wdata = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
                end else begin
                    mem_mode  = size_mode(f3_q);
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
                if (last_beat) state_nx = RESP;
            end
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, byte collection and response formation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            split_q <= 1'b0;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            rbuf_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        split_q <= req_mis && !TRAP_MISALIGN;
                        cnt_q   <= 2'd0;
                        last_q  <= (req_mis && !TRAP_MISALIGN) ?
                                   ((req_funct3[1:0] == 2'd2) ? 2'd3 : 2'd1) : 2'd0;
                        rbuf_q  <= 32'd0;
                        rdata_q <= 32'd0;
                        err_q   <= req_bad;
                    end
                end
                ACCESS: begin
                    rbuf_q <= merged;
                    cnt_q  <= cnt_q + 2'd1;
                    if (last_beat) rdata_q <= we_q ? 32'd0 : ext_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a little-endian byte memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int hold_req = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          t;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wd;
    } acc_t;
    acc_t acc_q[$];

    // 64-byte memory, addresses wrap on the low six bits.
    logic [7:0] mem [0:63];
    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    function automatic logic [5:0] ix(input logic [31:0] a, input int k);
        logic [31:0] s;
        s = a + k;
        return s[5:0];
    endfunction

    always_comb begin
        mem_rdata = 32'd0;
        case (mem_mode)
            3'b100: mem_rdata = {mem[ix(mem_addr,3)], mem[ix(mem_addr,2)],
                                 mem[ix(mem_addr,1)], mem[ix(mem_addr,0)]};
            3'b010: mem_rdata = {16'd0, mem[ix(mem_addr,1)], mem[ix(mem_addr,0)]};
            3'b001: mem_rdata = {24'd0, mem[ix(mem_addr,0)]};
            default: mem_rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            mem[ix(mem_addr,0)] <= mem_wdata[7:0];
            if (mem_mode != 3'b001) mem[ix(mem_addr,1)] <= mem_wdata[15:8];
            if (mem_mode == 3'b100) begin
                mem[ix(mem_addr,2)] <= mem_wdata[23:16];
                mem[ix(mem_addr,3)] <= mem_wdata[31:24];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory access logger.
    always @(negedge clk) begin
        if (!rst && mem_mode != 3'b000)
            acc_q.push_back('{we: mem_we, mode: mem_mode, addr: mem_addr, wd: mem_wdata});
    end

    // Response monitor: pops the scoreboard, checks hold stability, drives resp_ready.
    bit          in_resp = 1'b0;
    int          hold_left = 0;
    logic [31:0] cap_rd;
    logic        cap_err;
    always @(negedge clk) begin
        if (rst) begin
            in_resp    = 1'b0;
            resp_ready = 1'b1;
        end else if (resp_valid) begin
            if (!in_resp) begin
                exp_t e;
                in_resp = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp actual=%h required=none", resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rd);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("latency", cyc - e.t, e.lat);
                end
                cap_rd    = resp_rdata;
                cap_err   = resp_err;
                hold_left = hold_req;
            end else begin
                chk("hold_rdata", resp_rdata, cap_rd);
                chk("hold_err", {31'd0, resp_err}, {31'd0, cap_err});
                chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
                if (hold_left > 0) hold_left--;
            end
            resp_ready = (hold_left == 0);
        end else begin
            if (in_resp) begin
                in_resp = 1'b0;
                done_cnt++;
            end
            resp_ready = 1'b1;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] erd,
                          input logic eerr, input int elat, input int hold);
        int d0, n;
        wait_ready();
        acc_q.delete();
        hold_req = hold;
        d0 = done_cnt;
        exp_q.push_back('{rd: erd, err: eerr, lat: elat, t: cyc});
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 60) begin @(negedge clk); n++; end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL resp_timeout actual=none required=response");
        end
        hold_req = 0;
    endtask

    task automatic chk_acc(input int k, input logic we, input logic [2:0] mode,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] wmask);
        if (k >= acc_q.size()) begin
            checks++; errors++;
            $display("FAIL acc_missing actual=%0d required>%0d", acc_q.size(), k);
        end else begin
            chk("acc_we", {31'd0, acc_q[k].we}, {31'd0, we});
            chk("acc_mode", {29'd0, acc_q[k].mode}, {29'd0, mode});
            chk("acc_addr", acc_q[k].addr, a);
            chk("acc_wdata", acc_q[k].wd & wmask, wd);
        end
    endtask

    task automatic chk_outputs_reset(input string tag);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_mode"}, {29'd0, mem_mode}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [7:0] m3, m4;
        int n;
        #12;
        chk_outputs_reset("rst");
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Aligned word store and load.
        do_req(1'b1, 3'd2, 32'h0, 32'ha8a7a6a5, 32'h0, 1'b0, 2, 0);
        chk("sw_acc_count", acc_q.size(), 1);
        chk_acc(0, 1'b1, 3'b100, 32'h0, 32'ha8a7a6a5, 32'hffffffff);
        do_req(1'b0, 3'd2, 32'h0, 32'h0, 32'ha8a7a6a5, 1'b0, 2, 0);
        chk("lw_acc_we", {31'd0, acc_q[0].we}, 32'd0);

        // Sub-word loads with extension.
        do_req(1'b0, 3'd0, 32'h0, 32'h0, 32'hffffffa5, 1'b0, 2, 0);
        chk_acc(0, 1'b0, 3'b001, 32'h0, 32'h0, 32'h0);
        do_req(1'b0, 3'd4, 32'h0, 32'h0, 32'h000000a5, 1'b0, 2, 0);
        do_req(1'b0, 3'd1, 32'h2, 32'h0, 32'hffffa8a7, 1'b0, 2, 0);
        chk_acc(0, 1'b0, 3'b010, 32'h2, 32'h0, 32'h0);
        do_req(1'b0, 3'd5, 32'h2, 32'h0, 32'h0000a8a7, 1'b0, 2, 0);

`ifndef LSU_MISALIGN_TRAP_EN
        // Misaligned word store splits into four byte writes.
        do_req(1'b1, 3'd2, 32'h1, 32'h98badcfe, 32'h0, 1'b0, 5, 0);
        chk("split_sw_count", acc_q.size(), 4);
        chk_acc(0, 1'b1, 3'b001, 32'h1, 32'hfe, 32'hff);
        chk_acc(1, 1'b1, 3'b001, 32'h2, 32'hdc, 32'hff);
        chk_acc(2, 1'b1, 3'b001, 32'h3, 32'hba, 32'hff);
        chk_acc(3, 1'b1, 3'b001, 32'h4, 32'h98, 32'hff);
        do_req(1'b0, 3'd2, 32'h1, 32'h0, 32'h98badcfe, 1'b0, 5, 0);
        do_req(1'b0, 3'd1, 32'h3, 32'h0, 32'hffff98ba, 1'b0, 3, 0);
        // Split half load wrapping past the top of the address space.
        do_req(1'b0, 3'd5, 32'hffffffff, 32'h0, 32'h0000a500, 1'b0, 3, 0);
        chk("wrap_count", acc_q.size(), 2);
        chk_acc(0, 1'b0, 3'b001, 32'hffffffff, 32'h0, 32'h0);
        chk_acc(1, 1'b0, 3'b001, 32'h00000000, 32'h0, 32'h0);
`else
        // Misaligned accesses trap with no memory activity.
        m3 = mem[3]; m4 = mem[4];
        do_req(1'b1, 3'd1, 32'h3, 32'h00006587, 32'h0, 1'b1, 1, 0);
        chk("trap_sh_acc", acc_q.size(), 0);
        chk("trap_sh_mem3", {24'd0, mem[3]}, {24'd0, m3});
        chk("trap_sh_mem4", {24'd0, mem[4]}, {24'd0, m4});
        do_req(1'b0, 3'd2, 32'h1, 32'h0, 32'h0, 1'b1, 1, 0);
        chk("trap_lw_acc", acc_q.size(), 0);
`endif

        // Illegal funct3 codes.
        do_req(1'b0, 3'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        chk("ill_ld_acc", acc_q.size(), 0);
        do_req(1'b1, 3'd4, 32'h0, 32'h12345678, 32'h0, 1'b1, 1, 0);
        chk("ill_st_acc", acc_q.size(), 0);

        // Response held while resp_ready is low.
`ifndef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, 3'd2, 32'h0, 32'h0, 32'hbadcfea5, 1'b0, 2, 3);
`else
        do_req(1'b0, 3'd2, 32'h0, 32'h0, 32'ha8a7a6a5, 1'b0, 2, 3);
`endif

        // Reset in the middle of a store.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_wdata = 32'h11223344;
`ifndef LSU_MISALIGN_TRAP_EN
        req_addr = 32'h9;
`else
        req_addr = 32'h8;
`endif
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
`ifndef LSU_MISALIGN_TRAP_EN
        while (mem_addr != 32'ha && n < 10) begin @(negedge clk); n++; end
        chk("mid_rst_reach", mem_addr, 32'ha);
`else
        chk("mid_rst_reach", {29'd0, mem_mode}, 32'd4);
`endif
        rst = 1'b1;
        #1 chk_outputs_reset("mid_rst");
        @(negedge clk); rst = 1'b0;
        #1 chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
`ifndef LSU_MISALIGN_TRAP_EN
        chk("mid_rst_mem9", {24'd0, mem[9]}, 32'h44);
        chk("mid_rst_mem10", {24'd0, mem[10]}, 32'h00);
        do_req(1'b0, 3'd2, 32'h8, 32'h0, 32'h00004400, 1'b0, 2, 0);
`else
        chk("mid_rst_mem8", {24'd0, mem[8]}, 32'h00);
        do_req(1'b0, 3'd2, 32'h8, 32'h0, 32'h00000000, 1'b0, 2, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width on both request and memory sides.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1 and req_ready output 1, the request handshake; transfer occurs when both are high on a clk edge.
REQ-005 SHALL have ports req_we input 1 (1=store), req_funct3 input 3 (RISC-V load/store funct3), req_addr input ADDR_W, req_wdata input 32.
REQ-006 SHALL have ports resp_valid output 1, resp_ready input 1, resp_rdata output 32 (extended load data, 0 for stores), resp_err output 1.
REQ-007 SHALL have memory-side ports mem_we output 1, mem_mode output 3 (100=word, 010=half, 001=byte), mem_addr output ADDR_W, mem_wdata output 32, mem_rdata input 32.

Function
REQ-008 SHALL treat data memory as little-endian, byte-addressed, combinational read, write on the rising clk edge while mem_we=1; read data sits in low lanes, upper lanes zero.
REQ-009 SHALL implement states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL register the request on transfer and move IDLE->ACCESS, or IDLE->RESP with resp_err=1 and no memory access for illegal funct3 (loads other than 0,1,2,4,5; stores other than 0,1,2).
REQ-011 SHALL, for an aligned access (word addr[1:0]=0, half addr[0]=0, any byte), spend exactly one ACCESS cycle with mem_mode matching size, mem_addr=req_addr, mem_wdata=req_wdata.
REQ-012 SHALL, for a misaligned access, issue N byte-mode accesses (N=2 half, N=4 word) in consecutive ACCESS cycles at addr, addr+1, ..., lowest byte first, wrapping modulo 2^ADDR_W.
REQ-013 SHALL assert mem_we only in ACCESS cycles of a store; mem_we, mem_mode, mem_addr, mem_wdata SHALL be 0 outside ACCESS.
REQ-014 SHALL capture load bytes at the end of each ACCESS cycle and, entering RESP, form resp_rdata: LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged.
REQ-015 SHALL give resp_valid latency from request transfer of 1+N cycles (N=1 aligned), or 1 cycle for an error.
REQ-016 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready=1, then return to IDLE; a new request SHALL NOT be accepted in the same cycle.

Reset
REQ-017 SHALL, while rst=1, immediately force state IDLE and req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_mode=0, mem_addr=0, mem_wdata=0.
REQ-018 SHALL abandon a split access on reset mid-sequence; bytes already written stay written, no response is produced.

Configuration
REQ-019 SHALL honour macro LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses go IDLE->RESP with resp_err=1, resp_rdata=0, no memory access; when undefined, misaligned accesses split per REQ-012.

Structure
REQ-020 SHALL place mem_mode encodings, funct3 constants and the state enum in shared package lsu_pkg.
REQ-021 SHALL use one sub-module load_extend (combinational byte/half select plus sign/zero extension) instantiated once.

Verification
REQ-022 SHALL test SW 0xa8a7a6a5 @0 then LW @0 -> one mem_we cycle with mode 100, resp_rdata=0xa8a7a6a5, latency 2.
REQ-023 SHALL test after REQ-022 LB @0 -> 0xffffffa5; LBU @0 -> 0x000000a5; LH @2 -> 0xffffa8a7; LHU @2 -> 0x0000a8a7.
REQ-024 SHALL test, without macro, SW 0x98badcfe @1 -> 4 byte writes @1..4 data fe,dc,ba,98, resp_valid at cycle 5; then LW @1 -> 0x98badcfe.
REQ-025 SHALL test, with LSU_MISALIGN_TRAP_EN, SH 0x6587 @3 -> resp_err=1 after 1 cycle, mem_we never high, memory unchanged.
REQ-026 SHALL test load funct3=3 -> resp_err=1, no access; and rst pulsed during 2nd byte of a split SW -> outputs at reset values, next request served normally.
REQ-027 SHALL test resp_ready held low 3 cycles -> resp_valid/resp_rdata stable, req_ready=0 throughout.
